// File: rtl/spi_flash_rdid_slave.sv
// spi_flash_rdid_slave: SPI-flash responder (mode 0) that oversamples SCLK/CS_N/MOSI
// on clk, decodes the opcode byte and answers JEDEC Read-ID (0x9F) with a 3-byte ID.
// Optional feature macro: SPI_SLAVE_RDSR_EN adds Read-Status (0x05) returning STATUS_VAL.
module spi_flash_rdid_slave #(
    parameter logic [7:0] JEDEC_MFR  = 8'hEF,
    parameter logic [7:0] JEDEC_TYPE = 8'h40,
`ifdef SPI_SLAVE_RDSR_EN
    parameter logic [7:0] STATUS_VAL = 8'h00,
`endif
    parameter logic [7:0] JEDEC_CAP  = 8'h18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       rdid_done,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, CMD, RDID, STAT, IGNORE} state_t;

    state_t     state, next_state;
    logic [1:0] sclk_m, cs_n_m, mosi_m;   // [0] first stage, [1] synchronized value
    logic       sclk_d;
    logic       sclk_s, cs_n_s, mosi_s;
    logic       sclk_rise, sclk_fall;
    logic [1:0] settle;                   // edges since reset; sync chain valid at 2
    logic       armed;                    // cs_n has been seen high since reset
    logic [2:0] bit_cnt;
    logic [1:0] byte_idx;
    logic [7:0] rx_sr;
    logic [7:0] rx_byte;
    logic [7:0] tx_src;
    logic       tx_bit, miso_q;
    logic       shifting, cmd_done, id_done;

    assign sclk_s    = sclk_m[1];
    assign cs_n_s    = cs_n_m[1];
    assign mosi_s    = mosi_m[1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign rx_byte   = {rx_sr[6:0], mosi_s};
    assign shifting  = (state == RDID) || (state == STAT);
    assign busy      = ~cs_n_s;
    assign miso_oe   = shifting;
    assign miso      = shifting & miso_q;

    // Two-flop synchronizers plus a delayed SCLK copy for edge detection; reset to idle bus.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_m <= 2'b00;
            cs_n_m <= 2'b11;
            mosi_m <= 2'b00;
            sclk_d <= 1'b0;
        end else begin
            sclk_m <= {sclk_m[0], sclk};
            cs_n_m <= {cs_n_m[0], cs_n};
            mosi_m <= {mosi_m[0], mosi};
            sclk_d <= sclk_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode, completion strobes and response byte selection.
    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        next_state = state;
        cmd_done   = 1'b0;
        id_done    = 1'b0;
        tx_src     = JEDEC_MFR;
        case (state)
            IDLE: if (!cs_n_s && armed) next_state = CMD;
            CMD: begin
                if (sclk_rise && bit_cnt == 3'd7) begin
                    cmd_done = 1'b1;
                    case (rx_byte)
                        8'h9F:   next_state = RDID;
`ifdef SPI_SLAVE_RDSR_EN
                        8'h05:   next_state = STAT;
`endif
                        default: next_state = IGNORE;
                    endcase
                end
            end
            RDID: begin
                case (byte_idx)
                    2'd0:    tx_src = JEDEC_MFR;
                    2'd1:    tx_src = JEDEC_TYPE;
                    default: tx_src = JEDEC_CAP;
                endcase
                if (sclk_rise && bit_cnt == 3'd7 && byte_idx == 2'd2) id_done = 1'b1;
            end
`ifdef SPI_SLAVE_RDSR_EN
            STAT: tx_src = STATUS_VAL;
`endif
            default: ;
        endcase
        // Deselect wins over any simultaneous SCLK edge.
        if (cs_n_s) begin
            next_state = IDLE;
            cmd_done   = 1'b0;
            id_done    = 1'b0;
        end
    end

    // Datapath: arming after reset, bit/byte counters, shift registers and output pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle    <= 2'd0;
            armed     <= 1'b0;
            bit_cnt   <= 3'd0;
            byte_idx  <= 2'd0;
            rx_sr     <= 8'h00;
            tx_bit    <= 1'b0;
            miso_q    <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_byte  <= 8'h00;
            rdid_done <= 1'b0;
        end else begin
            if (settle != 2'd2) settle <= settle + 2'd1;
            if (settle == 2'd2 && cs_n_s) armed <= 1'b1;
            cmd_valid <= cmd_done;
            rdid_done <= id_done;
            miso_q    <= tx_bit;
            if (cmd_done) cmd_byte <= rx_byte;
            if (cs_n_s || state == IDLE) begin
                bit_cnt  <= 3'd0;
                byte_idx <= 2'd0;
                tx_bit   <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (state == CMD) rx_sr <= rx_byte;
                    if (shifting && bit_cnt == 3'd7)
                        byte_idx <= (byte_idx == 2'd2) ? 2'd0 : byte_idx + 2'd1;
                end
                // Bit index 7-bit_cnt: MSB first, presented on the fall before its rise.
                if (sclk_fall && shifting) tx_bit <= tx_src[3'd7 - bit_cnt];
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_rdid_slave.sv
// Directed testbench for spi_flash_rdid_slave; SCLK = clk/10, inputs driven and
// outputs sampled on the falling clk edge.
module tb_spi_flash_rdid_slave;

    logic       clk = 1'b0;
    logic       reset, sclk, cs_n, mosi;
    logic       miso, miso_oe, cmd_valid, rdid_done, busy;
    logic [7:0] cmd_byte;

    spi_flash_rdid_slave #(
        .JEDEC_MFR (8'hEF),
        .JEDEC_TYPE(8'h40),
`ifdef SPI_SLAVE_RDSR_EN
        .STATUS_VAL(8'hA5),
`endif
        .JEDEC_CAP (8'h18)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .cmd_valid(cmd_valid),
        .cmd_byte (cmd_byte),
        .rdid_done(rdid_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] ID [3] = '{8'hEF, 8'h40, 8'h18};
`ifdef SPI_SLAVE_RDSR_EN
    localparam logic [7:0] STAT_EXP = 8'hA5;
`else
    localparam logic [7:0] STAT_EXP = 8'h00;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cv_cnt = 0, rd_cnt = 0, oe_cnt = 0;
    logic [7:0] rxb [6];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Pulse and enable monitor; each one-clk pulse is seen on exactly one falling edge.
    always @(negedge clk) begin
        if (cmd_valid) cv_cnt++;
        if (rdid_done) rd_cnt++;
        if (miso_oe)   oe_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic frame_end();
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(6);
    endtask

    // Shift nbits of tx (MSB first); miso is sampled just before each rise.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7 - i];
            wait_clk(5);
            rx[7 - i] = miso;
            sclk = 1'b1;
            wait_clk(5);
            sclk = 1'b0;
        end
    endtask

    // Full frame: opcode then nbytes of response captured into rxb.
    task automatic frame(input logic [7:0] op, input int nbytes);
        logic [7:0] r;
        frame_begin();
        xfer(op, 8, r);
        for (int b = 0; b < nbytes; b++) begin
            xfer(8'h00, 8, r);
            rxb[b] = r;
        end
        frame_end();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".miso"},      32'(miso),      32'd0);
        check({tag, ".miso_oe"},   32'(miso_oe),   32'd0);
        check({tag, ".cmd_valid"}, 32'(cmd_valid), 32'd0);
        check({tag, ".cmd_byte"},  32'(cmd_byte),  32'h00);
        check({tag, ".rdid_done"}, 32'(rdid_done), 32'd0);
        check({tag, ".busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        int cv0, rd0, oe0;
        logic [7:0] r;
        reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        wait_clk(3);
        check_reset_outputs("rst");
        reset = 1'b0;
        wait_clk(4);

        // RDID, 24 response bits.
        cv0 = cv_cnt; rd0 = rd_cnt;
        frame_begin();
        check("rdid.busy", 32'(busy), 32'd1);
        xfer(8'h9F, 8, r);
        check("rdid.oe", 32'(miso_oe), 32'd1);
        for (int b = 0; b < 3; b++) begin
            xfer(8'h00, 8, r);
            check($sformatf("rdid.byte%0d", b), 32'(r), 32'(ID[b]));
        end
        frame_end();
        check("rdid.cv_cnt", 32'(cv_cnt - cv0), 32'd1);
        check("rdid.cmd_byte", 32'(cmd_byte), 32'h9F);
        check("rdid.done_cnt", 32'(rd_cnt - rd0), 32'd1);
        check("rdid.oe_off", 32'(miso_oe), 32'd0);

        // RDID, 48 bits: ID wraps and rdid_done pulses twice.
        rd0 = rd_cnt;
        frame(8'h9F, 6);
        for (int b = 0; b < 6; b++)
            check($sformatf("wrap.byte%0d", b), 32'(rxb[b]), 32'(ID[b % 3]));
        check("wrap.done_cnt", 32'(rd_cnt - rd0), 32'd2);

        // Unknown opcode 0x03: no drive at all.
        oe0 = oe_cnt;
        frame(8'h03, 2);
        check("ign.cmd_byte", 32'(cmd_byte), 32'h03);
        check("ign.byte0", 32'(rxb[0]), 32'h00);
        check("ign.byte1", 32'(rxb[1]), 32'h00);
        check("ign.oe_cnt", 32'(oe_cnt - oe0), 32'd0);

        // Read-Status 0x05 (A5 with the feature, zeros without).
        frame(8'h05, 2);
        check("stat.cmd_byte", 32'(cmd_byte), 32'h05);
        check("stat.byte0", 32'(rxb[0]), 32'(STAT_EXP));
        check("stat.byte1", 32'(rxb[1]), 32'(STAT_EXP));

        // Aborted opcode after 5 bits, then a clean RDID frame.
        cv0 = cv_cnt;
        frame_begin();
        xfer(8'h9F, 5, r);
        frame_end();
        check("abort.cv_cnt", 32'(cv_cnt - cv0), 32'd0);
        frame(8'h9F, 3);
        for (int b = 0; b < 3; b++)
            check($sformatf("abort.byte%0d", b), 32'(rxb[b]), 32'(ID[b]));
        check("abort.cv_after", 32'(cv_cnt - cv0), 32'd1);

        // Reset midway through the second ID byte with cs_n held low.
        frame_begin();
        xfer(8'h9F, 8, r);
        xfer(8'h00, 8, r);
        check("mid.byte0", 32'(r), 32'(ID[0]));
        xfer(8'h00, 4, r);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        wait_clk(2);
        reset = 1'b0;
        // cs_n still low: a full 0x9F must not be taken as a new frame.
        cv0 = cv_cnt; oe0 = oe_cnt;
        xfer(8'h9F, 8, r);
        wait_clk(6);
        check("unarmed.cv_cnt", 32'(cv_cnt - cv0), 32'd0);
        check("unarmed.cmd_byte", 32'(cmd_byte), 32'h00);
        check("unarmed.oe_cnt", 32'(oe_cnt - oe0), 32'd0);
        frame_end();
        rd0 = rd_cnt;
        frame(8'h9F, 3);
        for (int b = 0; b < 3; b++)
            check($sformatf("post.byte%0d", b), 32'(rxb[b]), 32'(ID[b]));
        check("post.cmd_byte", 32'(cmd_byte), 32'h9F);
        check("post.done_cnt", 32'(rd_cnt - rd0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_flash_rdid_slave.md
# spi_flash_rdid_slave

SPI-flash responder on the far side of the SPI bus from `spi_master`, consuming the SCLK/CS_N/MOSI traffic it produces and returning MISO data. It oversamples the bus on the system clock, decodes the opcode byte, and answers JEDEC Read-ID (0x9F) with a 3-byte ID. Optionally it also answers Read-Status (0x05). The block serves as the synthesizable bus partner for bring-up of the master's RDID sequence and for loopback self-test.

## Interface
- `JEDEC_MFR`, 8'hEF, manufacturer ID byte (sent first)
- `JEDEC_TYPE`, 8'h40, memory type byte (sent second)
- `JEDEC_CAP`, 8'h18, capacity byte (sent third)
- `STATUS_VAL`, 8'h00, byte returned for Read-Status
- `clk  input  1  system clock; all logic on rising edge`
- `reset  input  1  asynchronous, active-high reset`
- `sclk  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0), asynchronous to clk`
- `cs_n  input  1  chip select, active low, asynchronous to clk`
- `mosi  input  1  serial data from master, MSB first`
- `miso  output  1  serial data to master, MSB first`
- `miso_oe  output  1  high while selected and driving a response`
- `cmd_valid  output  1  one-clk pulse when an opcode byte completes`
- `cmd_byte  output  8  last received opcode; held until next cmd_valid`
- `rdid_done  output  1  one-clk pulse after the third ID byte is fully shifted`
- `busy  output  1  high whenever synchronized cs_n is low`

## Operation
- Input conditioning: `sclk`, `cs_n`, `mosi` each pass through a 2-flop synchronizer. Rise/fall of `sclk` are detected from the synchronized value against one further registered copy.
- FSM states:
  - IDLE: leave IDLE when synchronized `cs_n` goes low; enter CMD.
  - CMD: sample `mosi` into the shift register on each SCLK rise. After the 8th rise, load `cmd_byte` and pulse `cmd_valid`. Then:
    - 0x9F -> RDID
    - 0x05 -> STAT (macro-enabled only)
    - anything else -> IGNORE
  - RDID: shift out `JEDEC_MFR`, `JEDEC_TYPE`, `JEDEC_CAP`. Each new bit is presented on SCLK fall. The first MSB is presented on the fall that follows the 8th command rise. Pulse `rdid_done` on the 8th rise of the third byte. If clocking continues, the sequence wraps to `JEDEC_MFR`; `rdid_done` pulses again on every third-byte completion.
  - STAT: shift `STATUS_VAL` repeatedly, with the same edge rules as RDID.
  - IGNORE: `miso`=0, `miso_oe`=0; consume clocks until deselect.
- Counters: 3-bit bit counter, wraps 7->0 at byte boundary. 2-bit byte index counts 0,1,2, then back to 0 (3 is never reached).
- Deselect: synchronized `cs_n` high in any state returns the FSM to IDLE on the next clk. A partial byte is discarded; no `cmd_valid` is issued for an incomplete opcode. Counters clear.
- Outputs:
  - `miso` = 0 and `miso_oe` = 0 outside RDID/STAT.
  - `busy` = !synchronized `cs_n`.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `cmd_valid`=0, `cmd_byte`=8'h00, `rdid_done`=0, `busy`=0; FSM in IDLE; synchronizers = idle bus (`sclk`=0, `cs_n`=1).
- Input-to-edge-detect latency: 3 clk. `cmd_valid` asserts 3 clk after the 8th raw SCLK rise.
- `miso` update latency: 4 clk after a raw SCLK fall (3 detect + 1 output register). The master must therefore hold SCLK low and high each ≥5 clk periods; faster SCLK is unsupported.
- `cs_n` low → `busy` high: 2 clk. `cs_n` high → IDLE and `miso_oe` low: 3 clk.
- SCLK edge and `cs_n` rise in the same synchronized clk: deselect wins; the edge is ignored.
- `reset` mid-transaction: all state clears immediately (asynchronous). After `reset` falls, the block resynchronizes and waits for a fresh `cs_n` fall. It must not treat an already-low `cs_n` as a new frame until `cs_n` has been seen high.

## Configuration
- `SPI_SLAVE_RDSR_EN`:
  - Defined: STAT state and the 0x05 decode are compiled in.
  - Undefined: 0x05 is treated as an unknown opcode and goes to IGNORE. STAT logic and `STATUS_VAL` usage are absent. `cmd_valid` and `cmd_byte` still report 0x05.

## Test plan
- RDID at SCLK = clk/10: select, send 0x9F, clock 24 bits -> MISO reads 0xEF,0x40,0x18; one `cmd_valid` with `cmd_byte`=0x9F; one `rdid_done`.
- RDID with 48 bits clocked -> MISO reads 0xEF,0x40,0x18,0xEF,0x40,0x18; `rdid_done` pulses twice.
- Opcode 0x03, then 16 clocks -> `cmd_byte`=0x03, `miso`=0 and `miso_oe`=0 throughout.
- With `SPI_SLAVE_RDSR_EN` and `STATUS_VAL`=8'hA5: send 0x05, clock 16 bits -> MISO reads 0xA5,0xA5. Without the macro -> MISO reads all 0.
- Deselect after 5 opcode bits, then a full 0x9F frame -> no `cmd_valid` for the aborted frame; the second frame returns the correct ID.
- Assert `reset` for 2 clk mid-way through the second ID byte -> all outputs at reset values within 1 clk. The next full frame returns 0xEF,0x40,0x18.
